pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 pipeline. It holds the fetch-stage predicted-PC register (`F_predPC`) that the PC-select logic reads. It watches the D, E, M and W stage signals and issues per-stage stall and bubble controls for load-use hazards, `ret` draining, mispredicted `jXX` and exceptions. A small run/halt state machine freezes the machine after a non-AOK status retires, and it keeps cycle and bubble performance counters.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports (clk and reset first):
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `f_predPC`  in  64: next predicted PC from the predictor.
- `D_icode`, `E_icode`, `M_icode`  in  4 each: icodes held in the D, E and M pipeline registers.
- `E_dstM`  in  4: load destination register in E.
- `d_srcA`, `d_srcB`  in  4 each: source registers being decoded.
- `e_Cnd`  in  1: condition result computed in execute.
- `m_stat`, `W_stat`  in  3 each: status in the memory stage and the write-back stage.
- `F_predPC`  out  64: registered predicted PC.
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall`  out  1 each: pipeline-register controls.
- `halted`  out  1: high in the HALTED state.
- `final_stat`  out  3: `W_stat` captured on entry to HALTED.
- `cyc_cnt`, `bub_cnt`  out  `CNT_W` each: performance counters.

## Operation
Encodings:
- icodes: JXX=7, RET=9, MRMOVQ=5, POPQ=11.
- stat: AOK=1, HLT=2, ADR=3, INS=4.
- RNONE=15. `E_dstM`=RNONE never matches a source register.

Conditions (combinational):
- load_use = (E_icode ∈ {5,11}) && E_dstM≠RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
- ret_in = RET present in D_icode, E_icode or M_icode.
- mispred = E_icode==7 && !e_Cnd.
- exc_m = m_stat ∈ {2,3,4}.
- exc_w = W_stat ∈ {2,3,4}.

Outputs in RUN and DRAIN:
- F_stall = load_use || ret_in.
- D_stall = load_use.
- D_bubble = mispred || (ret_in && !load_use).
- E_bubble = mispred || load_use.
- M_bubble = exc_m || exc_w.
- W_stall = exc_w.

State machine:
- RUN → DRAIN when exc_m.
- RUN → HALTED when exc_w.
- DRAIN → HALTED when exc_w.
- DRAIN → RUN when exc_m and exc_w are both low. This covers an excepting instruction squashed before retiring.
- HALTED is absorbing until reset. In HALTED: F_stall=D_stall=W_stall=1, M_bubble=1, D_bubble=E_bubble=0, and `halted`=1.

F_predPC register:
- Loads `f_predPC` on each edge where F_stall=0.
- Holds otherwise.

Counters:
- `cyc_cnt` increments every cycle while not HALTED.
- `bub_cnt` increments on cycles where D_bubble||E_bubble and not HALTED.
- Both saturate at all-ones; they never wrap.

`final_stat` loads W_stat on the RUN/DRAIN→HALTED edge and is stable thereafter.

## Timing
- Control outputs are combinational from the current-cycle inputs. Pipeline registers act on them at the same edge, so control latency is zero cycles.
- Registered outputs update one edge after their cause.
- Reset (asynchronous, immediate) sets: F_predPC=0, state RUN, `halted`=0, `final_stat`=AOK(1), both counters 0.
- While rst is high, control outputs are forced to: D_bubble=E_bubble=M_bubble=1, all stalls 0.
- Reset asserted mid-operation, including in HALTED, takes effect immediately. The first post-reset edge loads `f_predPC`.
- `ret` causes 3 consecutive D bubbles, one while RET is in each of D, E and M. F is stalled in those cycles.
- A mispredicted jump causes 1 D bubble and 1 E bubble in the same cycle.
- Simultaneous load_use and ret_in (RET in D, load in E): the stall wins. D_stall=1, D_bubble=0, E_bubble=1.
- Simultaneous mispred and load_use: E_bubble=1, D_bubble=1, D_stall=1. The bench must accept this combination; the pipeline register gives bubble priority.
- Simultaneous exc_m and exc_w: go directly to HALTED.

## Structure
- Shared package `y86_pkg` holds: icode constants, stat codes, RNONE, and the state enum {RUN, DRAIN, HALTED}. The existing predictor and select blocks use the same package.
- One combinational sub-module, `hazard_detect`, produces load_use, ret_in, mispred, exc_m and exc_w.
- The top level holds the FSM, the F_predPC register, the counters and the output muxing.

## Test plan
- Reset mid-run with f_predPC=0x40: reset clears everything (F_predPC=0, counters 0, state RUN). The first edge after release gives F_predPC=0x40.
- Load-use: E_icode=5, E_dstM=3, d_srcA=3. Expect F_stall=D_stall=E_bubble=1 and D_bubble=0; F_predPC holds its value; bub_cnt +1.
- RET walks D→E→M over 3 cycles: F_stall=1 and D_bubble=1 each cycle; bub_cnt +3. In the 4th cycle F_predPC loads again.
- Mispredict: E_icode=7, e_Cnd=0. D_bubble=E_bubble=1 for exactly one cycle; F_stall=0.
- Exception path: m_stat=3 for one cycle → DRAIN with M_bubble=1. Next cycle W_stat=3 → HALTED with final_stat=3 and halted=1. cyc_cnt then freezes and all stalls stay at 1 for 10 further cycles.
- Counter saturation: with CNT_W=4, run 20 cycles and confirm cyc_cnt stops at 15.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the pipeline-control state type.
package y86_pkg;

  // Instruction codes that the control logic cares about
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_POPQ   = 4'd11;

  // Register id meaning "no register"
  localparam logic [3:0] RNONE = 4'd15;

  // Status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // Run/halt controller states
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } ctrl_state_t;

  // True for any status that stops the machine
  function automatic logic is_exc(input logic [2:0] stat);
    return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard and exception detection from the D/E/M/W stage fields.
module hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] M_icode,
  input  logic [3:0] E_dstM,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic       e_Cnd,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       load_use,
  output logic       ret_in,
  output logic       mispred,
  output logic       exc_m,
  output logic       exc_w
);

  // Hazard conditions; a load into RNONE never creates a dependency
  always_comb begin
    load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
               (E_dstM != RNONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_in   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mispred  = (E_icode == I_JXX) && !e_Cnd;
    exc_m    = is_exc(m_stat);
    exc_w    = is_exc(W_stat);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, predicted-PC register,
// run/drain/halt sequencing and saturating performance counters.
// There are no valid/ready handshakes here: every control output is a level
// that the pipeline registers sample on the same rising edge.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       f_predPC,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        M_icode,
  input  logic [3:0]        E_dstM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  input  logic              e_Cnd,
  input  logic [2:0]        m_stat,
  input  logic [2:0]        W_stat,
  output logic [63:0]       F_predPC,
  output logic              F_stall,
  output logic              D_stall,
  output logic              D_bubble,
  output logic              E_bubble,
  output logic              M_bubble,
  output logic              W_stall,
  output logic              halted,
  output logic [2:0]        final_stat,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  bub_cnt,
  output ctrl_state_t       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic load_use, ret_in, mispred, exc_m, exc_w;

  ctrl_state_t      state_q, state_d;
  logic [63:0]      pred_pc_q, pred_pc_d;
  logic [2:0]       final_stat_q, final_stat_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;

  hazard_detect u_hazard (
    .D_icode  (D_icode),
    .E_icode  (E_icode),
    .M_icode  (M_icode),
    .E_dstM   (E_dstM),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .e_Cnd    (e_Cnd),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .load_use (load_use),
    .ret_in   (ret_in),
    .mispred  (mispred),
    .exc_m    (exc_m),
    .exc_w    (exc_w)
  );

  // Control outputs: bubbles everywhere during reset, frozen when halted,
  // otherwise the hazard rules (a load-use stall beats the ret bubble in D)
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    if (rst) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (state_q == ST_HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
      M_bubble = 1'b1;
    end else begin
      F_stall  = load_use || ret_in;
      D_stall  = load_use;
      D_bubble = mispred || (ret_in && !load_use);
      E_bubble = mispred || load_use;
      M_bubble = exc_m || exc_w;
      W_stall  = exc_w;
    end
  end

  // Run/halt next state; an exception retiring in W halts straight away,
  // one still in M only drains, and a squashed one falls back to RUN
  always_comb begin
    state_d      = state_q;
    final_stat_d = final_stat_q;
    case (state_q)
      ST_RUN: begin
        if (exc_w) begin
          state_d      = ST_HALTED;
          final_stat_d = W_stat;
        end else if (exc_m) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (exc_w) begin
          state_d      = ST_HALTED;
          final_stat_d = W_stat;
        end else if (!exc_m) begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Predicted-PC load and saturating counters, all idle once halted
  always_comb begin
    pred_pc_d = F_stall ? pred_pc_q : f_predPC;
    cyc_cnt_d = cyc_cnt_q;
    bub_cnt_d = bub_cnt_q;
    if (state_q != ST_HALTED) begin
      if (cyc_cnt_q != CNT_MAX) cyc_cnt_d = cyc_cnt_q + CNT_ONE;
      if ((D_bubble || E_bubble) && (bub_cnt_q != CNT_MAX)) bub_cnt_d = bub_cnt_q + CNT_ONE;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pred_pc_q    <= 64'd0;
      final_stat_q <= S_AOK;
      cyc_cnt_q    <= '0;
      bub_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pred_pc_q    <= pred_pc_d;
      final_stat_q <= final_stat_d;
      cyc_cnt_q    <= cyc_cnt_d;
      bub_cnt_q    <= bub_cnt_d;
    end
  end

  assign F_predPC   = pred_pc_q;
  assign halted     = (state_q == ST_HALTED);
  assign final_stat = final_stat_q;
  assign cyc_cnt    = cyc_cnt_q;
  assign bub_cnt    = bub_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the control rules.
module tb_pipe_ctrl;
  import y86_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [63:0] f_predPC;
  logic [3:0]  D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
  logic        e_Cnd;
  logic [2:0]  m_stat, W_stat;

  logic [63:0] F_predPC, F_predPC_4;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic F_stall_4, D_stall_4, D_bubble_4, E_bubble_4, M_bubble_4, W_stall_4, halted_4;
  logic [2:0]  final_stat, final_stat_4;
  logic [31:0] cyc_cnt, bub_cnt;
  logic [3:0]  cyc_cnt_4, bub_cnt_4;
  ctrl_state_t dbg_state, dbg_state_4;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .f_predPC(f_predPC),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .E_dstM(E_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_predPC(F_predPC), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall), .halted(halted),
    .final_stat(final_stat), .cyc_cnt(cyc_cnt), .bub_cnt(bub_cnt), .dbg_state(dbg_state)
  );

  // Narrow-counter instance, same stimulus, for saturation
  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .f_predPC(f_predPC),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .E_dstM(E_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_predPC(F_predPC_4), .F_stall(F_stall_4), .D_stall(D_stall_4), .D_bubble(D_bubble_4),
    .E_bubble(E_bubble_4), .M_bubble(M_bubble_4), .W_stall(W_stall_4), .halted(halted_4),
    .final_stat(final_stat_4), .cyc_cnt(cyc_cnt_4), .bub_cnt(bub_cnt_4), .dbg_state(dbg_state_4)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected controls straight from the rules, packed {fs,ds,db,eb,mb,ws}
  logic m_halted, m_drain;
  logic [63:0] m_pc, m_cyc, m_bub;
  logic [2:0]  m_fstat;

  wire lu = ((E_icode == 4'd5) || (E_icode == 4'd11)) && (E_dstM != 4'd15) &&
            ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  wire ri = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
  wire mp = (E_icode == 4'd7) && !e_Cnd;
  wire em = (m_stat >= 3'd2) && (m_stat <= 3'd4);
  wire ew = (W_stat >= 3'd2) && (W_stat <= 3'd4);
  wire [5:0] exp_c = rst      ? 6'b001110 :
                     m_halted ? 6'b110011 :
                     {lu || ri, lu, mp || (ri && !lu), mp || lu, em || ew, ew};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_halted <= 1'b0; m_drain <= 1'b0; m_pc <= 64'd0;
      m_cyc <= 64'd0; m_bub <= 64'd0; m_fstat <= 3'd1;
    end else begin
      if (!exp_c[5]) m_pc <= f_predPC;
      if (!m_halted) begin
        m_cyc <= m_cyc + 64'd1;
        if (exp_c[3] || exp_c[2]) m_bub <= m_bub + 64'd1;
        if (ew) begin
          m_halted <= 1'b1;
          m_fstat  <= W_stat;
        end else begin
          m_drain <= em;
        end
      end
    end
  end

  function automatic logic [63:0] sat(input logic [63:0] v, input logic [63:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("F_stall",  F_stall,  exp_c[5]);
      check("D_stall",  D_stall,  exp_c[4]);
      check("D_bubble", D_bubble, exp_c[3]);
      check("E_bubble", E_bubble, exp_c[2]);
      check("M_bubble", M_bubble, exp_c[1]);
      check("W_stall",  W_stall,  exp_c[0]);
      check("F_predPC", F_predPC, m_pc);
      check("halted",   halted,   m_halted);
      check("state",    dbg_state, m_halted ? ST_HALTED : (m_drain ? ST_DRAIN : ST_RUN));
      check("final_stat", final_stat, m_fstat);
      check("cyc_cnt",  cyc_cnt,  sat(m_cyc, 64'hFFFF_FFFF));
      check("bub_cnt",  bub_cnt,  sat(m_bub, 64'hFFFF_FFFF));
      check("cyc_cnt_4", cyc_cnt_4, sat(m_cyc, 64'd15));
      check("bub_cnt_4", bub_cnt_4, sat(m_bub, 64'd15));
      check("F_predPC_4", F_predPC_4, m_pc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    D_icode = 4'd0; E_icode = 4'd0; M_icode = 4'd0;
    E_dstM = 4'd15; d_srcA = 4'd15; d_srcB = 4'd15;
    e_Cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic rand_inputs();
    f_predPC = {$urandom, $urandom};
    D_icode  = 4'($urandom_range(0, 11));
    E_icode  = 4'($urandom_range(0, 11));
    M_icode  = 4'($urandom_range(0, 11));
    E_dstM   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    d_srcA   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    d_srcB   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    e_Cnd    = 1'($urandom_range(0, 1));
    m_stat   = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1));
    W_stat   = ($urandom_range(0, 59) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
  endtask

  // Assert reset mid-cycle, hold across one edge, release mid-cycle
  task automatic do_reset();
    #1 rst = 1'b1;
    step();
    #2 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] pc_s, bub_s, cyc_s;

  initial begin
    set_idle();
    f_predPC = 64'h100;
    chk_en = 1'b1;
    repeat (2) step();
    #2 rst = 1'b0;

    // Reset in the middle of activity
    repeat (5) begin f_predPC = {$urandom, $urandom}; step(); end
    f_predPC = 64'h40;
    #1 rst = 1'b1;
    #1;
    check("rst_F_predPC", F_predPC, 64'd0);
    check("rst_cyc_cnt", cyc_cnt, 64'd0);
    check("rst_D_bubble", D_bubble, 64'd1);
    check("rst_F_stall", F_stall, 64'd0);
    step();
    #2 rst = 1'b0;
    step();
    check("first_load_F_predPC", F_predPC, 64'h40);
    check("first_load_cyc_cnt", cyc_cnt, 64'd1);

    // Load-use: stall F/D, bubble E
    set_idle();
    step();
    pc_s = m_pc; bub_s = m_bub;
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3; f_predPC = 64'h200;
    #2;
    check("lu_F_stall", F_stall, 64'd1);
    check("lu_D_stall", D_stall, 64'd1);
    check("lu_E_bubble", E_bubble, 64'd1);
    check("lu_D_bubble", D_bubble, 64'd0);
    step();
    check("lu_pc_hold", F_predPC, pc_s);
    check("lu_bub_inc", bub_cnt, bub_s + 64'd1);
    set_idle();

    // RET walks D -> E -> M
    pc_s = m_pc; bub_s = m_bub;
    D_icode = 4'd9;
    #1;
    check("ret_F_stall", F_stall, 64'd1);
    check("ret_D_bubble", D_bubble, 64'd1);
    step();
    D_icode = 4'd0; E_icode = 4'd9; step();
    E_icode = 4'd0; M_icode = 4'd9; step();
    M_icode = 4'd0;
    check("ret_pc_hold", F_predPC, pc_s);
    check("ret_bub_3", bub_cnt, bub_s + 64'd3);
    f_predPC = 64'h300;
    step();
    check("ret_pc_resume", F_predPC, 64'h300);

    // Mispredicted jump: single-cycle D and E bubble
    E_icode = 4'd7; e_Cnd = 1'b0;
    #1;
    check("mp_D_bubble", D_bubble, 64'd1);
    check("mp_E_bubble", E_bubble, 64'd1);
    check("mp_F_stall", F_stall, 64'd0);
    step();
    set_idle();
    #1;
    check("mp_one_cycle", D_bubble, 64'd0);

    // Exception in M then retiring in W
    m_stat = 3'd3;
    step();
    check("exc_drain", dbg_state, ST_DRAIN);
    m_stat = 3'd1; W_stat = 3'd3;
    #1;
    check("exc_M_bubble", M_bubble, 64'd1);
    step();
    check("exc_halted", halted, 64'd1);
    check("exc_final_stat", final_stat, 64'd3);
    cyc_s = m_cyc;
    repeat (10) begin
      rand_inputs();
      step();
      check("halt_F_stall", F_stall, 64'd1);
      check("halt_W_stall", W_stall, 64'd1);
      check("halt_cyc_frozen", cyc_cnt, cyc_s);
      check("halt_final_stat", final_stat, 64'd3);
    end

    // Reset out of HALTED, then narrow counter saturation
    set_idle();
    do_reset();
    repeat (20) step();
    check("sat_cyc_cnt_4", cyc_cnt_4, 64'd15);
    check("sat_cyc_cnt_32", cyc_cnt, 64'd20);

    // Randomized traffic with periodic resets
    repeat (6) begin
      do_reset();
      repeat (150) begin
        rand_inputs();
        step();
      end
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
